// File: rtl/acc_sched_pkg.sv
// Shared types and default sizing for the two-requester running-sum arbiter.
package acc_sched_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_LIM_W = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    ACCUM = 2'd2,
    WRITE = 2'd3
  } state_t;

  typedef enum logic {
    OWN_A = 1'b0,
    OWN_B = 1'b1
  } owner_t;

endpackage

// File: rtl/acc_sum_arbiter_if.sv
// Request/grant/result bundle between the two requesters and the sum arbiter.
interface acc_sum_arbiter_if
  import acc_sched_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int LIM_W = DEF_LIM_W
);

  logic             req_a;
  logic [LIM_W-1:0] lim_a;
  logic             req_b;
  logic [LIM_W-1:0] lim_b;
  logic             gnt_a;
  logic             gnt_b;
  logic             done_a;
  logic             done_b;
  logic [WIDTH-1:0] res_a;
  logic [WIDTH-1:0] res_b;
  logic             busy;

  modport master (
    output req_a, lim_a, req_b, lim_b,
    input  gnt_a, gnt_b, done_a, done_b, res_a, res_b, busy
  );

  modport slave (
    input  req_a, lim_a, req_b, lim_b,
    output gnt_a, gnt_b, done_a, done_b, res_a, res_b, busy
  );

endinterface

// File: rtl/acc_datapath.sv
// Shared counter / W accumulator / adder; sequenced by the arbiter FSM.
module acc_datapath #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             cnt_en,
  input  logic             load_w,
  output logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] w,
  output logic [WIDTH-1:0] sum
);

  logic [WIDTH-1:0] count_reg;
  logic [WIDTH-1:0] w_reg;

  assign sum   = count_reg + WIDTH'(1) + w_reg;
  assign count = count_reg;
  assign w     = w_reg;

  always_ff @(negedge clk or posedge reset) begin
    if (reset) begin
      count_reg <= '0;
      w_reg     <= '0;
    end else if (clr) begin
      count_reg <= '0;
      w_reg     <= '0;
    end else begin
      if (cnt_en) count_reg <= count_reg + WIDTH'(1);
      if (load_w) w_reg <= sum;
    end
  end

endmodule

// File: rtl/acc_sum_arbiter.sv
// Round-robin arbiter sharing one running-sum datapath between requesters A and B.
module acc_sum_arbiter
  import acc_sched_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int LIM_W = DEF_LIM_W
) (
  input logic             clk,
  input logic             reset,
  acc_sum_arbiter_if.slave bus
);

  state_t           state_reg, state_next;
  owner_t           owner_reg, owner_next;
  logic [LIM_W-1:0] lim_reg, lim_next;
  logic             prio_b_reg, prio_b_next;
  logic             gnt_a_reg, gnt_a_next;
  logic             gnt_b_reg, gnt_b_next;
  logic             done_a_reg, done_a_next;
  logic             done_b_reg, done_b_next;
  logic [WIDTH-1:0] res_a_reg, res_a_next;
  logic [WIDTH-1:0] res_b_reg, res_b_next;

  logic             clr, cnt_en, load_w;
  logic [WIDTH-1:0] count, w, sum;

  acc_datapath #(.WIDTH(WIDTH)) u_datapath (
    .clk    (clk),
    .reset  (reset),
    .clr    (clr),
    .cnt_en (cnt_en),
    .load_w (load_w),
    .count  (count),
    .w      (w),
    .sum    (sum)
  );

  always_ff @(negedge clk or posedge reset) begin
    if (reset) begin
      state_reg  <= IDLE;
      owner_reg  <= OWN_A;
      lim_reg    <= '0;
      prio_b_reg <= 1'b0;
      gnt_a_reg  <= 1'b0;
      gnt_b_reg  <= 1'b0;
      done_a_reg <= 1'b0;
      done_b_reg <= 1'b0;
      res_a_reg  <= '0;
      res_b_reg  <= '0;
    end else begin
      state_reg  <= state_next;
      owner_reg  <= owner_next;
      lim_reg    <= lim_next;
      prio_b_reg <= prio_b_next;
      gnt_a_reg  <= gnt_a_next;
      gnt_b_reg  <= gnt_b_next;
      done_a_reg <= done_a_next;
      done_b_reg <= done_b_next;
      res_a_reg  <= res_a_next;
      res_b_reg  <= res_b_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    owner_next  = owner_reg;
    lim_next    = lim_reg;
    prio_b_next = prio_b_reg;
    gnt_a_next  = 1'b0;
    gnt_b_next  = 1'b0;
    done_a_next = 1'b0;
    done_b_next = 1'b0;
    res_a_next  = res_a_reg;
    res_b_next  = res_b_reg;
    clr         = 1'b0;
    cnt_en      = 1'b0;
    load_w      = 1'b0;
    case (state_reg)
      IDLE: begin
        if (bus.req_a || bus.req_b) begin
          // prio_b_reg set means A was granted last, so B wins a tie
          if (bus.req_a && (!bus.req_b || !prio_b_reg)) begin
            owner_next  = OWN_A;
            lim_next    = bus.lim_a;
            gnt_a_next  = 1'b1;
            prio_b_next = 1'b1;
          end else begin
            owner_next  = OWN_B;
            lim_next    = bus.lim_b;
            gnt_b_next  = 1'b1;
            prio_b_next = 1'b0;
          end
          state_next = LOAD;
        end
      end
      LOAD: begin
        clr        = 1'b1;
        state_next = (lim_reg == '0) ? WRITE : ACCUM;
      end
      ACCUM: begin
        cnt_en = 1'b1;
        load_w = 1'b1;
        if (count + WIDTH'(1) == WIDTH'(lim_reg)) state_next = WRITE;
      end
      WRITE: begin
        if (owner_reg == OWN_A) begin
          res_a_next  = w;
          done_a_next = 1'b1;
        end else begin
          res_b_next  = w;
          done_b_next = 1'b1;
        end
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Adder consistency, sampled on the idle clock phase when the datapath is settled.
  always @(posedge clk) begin
    if (!reset && load_w) assert (sum == w + count + WIDTH'(1));
  end

  assign bus.gnt_a  = gnt_a_reg;
  assign bus.gnt_b  = gnt_b_reg;
  assign bus.done_a = done_a_reg;
  assign bus.done_b = done_b_reg;
  assign bus.res_a  = res_a_reg;
  assign bus.res_b  = res_b_reg;
  assign bus.busy   = (state_reg != IDLE);

endmodule

// File: tb/tb_acc_sum_arbiter.sv
// Scoreboard bench: drivers queue expected sums, a monitor checks grants, results and latency.
module tb_acc_sum_arbiter;

  localparam int WIDTH = 8;
  localparam int LIM_W = 5;

  logic clk = 1'b0;
  logic reset = 1'b1;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  int exp_a[$];
  int exp_b[$];

  bit idle_m   = 1'b1;
  bit prio_b_m = 1'b0;
  bit edge_ra  = 1'b0;
  bit edge_rb  = 1'b0;
  bit any_g, exp_g, a_wins;
  int gnt_cyc_a = 0;
  int gnt_cyc_b = 0;
  int n_pop, e_pop;
  logic [WIDTH-1:0] last_a = '0;
  logic [WIDTH-1:0] last_b = '0;

  acc_sum_arbiter_if #(.WIDTH(WIDTH), .LIM_W(LIM_W)) bus ();

  acc_sum_arbiter #(.WIDTH(WIDTH), .LIM_W(LIM_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) cyc <= cyc + 1;

  function automatic int ref_sum(input int n);
    return (n * (n + 1) / 2) % (1 << WIDTH);
  endfunction

  task automatic check(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Requests as the DUT sees them on its active (falling) edge
  always @(negedge clk) begin
    edge_ra = reset ? 1'b0 : bus.req_a;
    edge_rb = reset ? 1'b0 : bus.req_b;
  end

  always @(posedge clk) begin
    if (reset) begin
      idle_m   = 1'b1;
      prio_b_m = 1'b0;
      last_a   = '0;
      last_b   = '0;
    end else begin
      any_g = bus.gnt_a | bus.gnt_b;
      exp_g = idle_m && (edge_ra || edge_rb);
      check("gnt_when_idle_and_requested", any_g, exp_g);
      check("gnt_onehot", bus.gnt_a & bus.gnt_b, 0);
      check("gnt_done_same_a", bus.gnt_a & bus.done_a, 0);
      check("gnt_done_same_b", bus.gnt_b & bus.done_b, 0);
      if (exp_g) begin
        a_wins = edge_ra && (!edge_rb || !prio_b_m);
        check("winner_a", bus.gnt_a, a_wins);
        check("winner_b", bus.gnt_b, !a_wins);
        check("busy_after_gnt", bus.busy, 1);
        prio_b_m = a_wins;
        idle_m   = 1'b0;
        if (a_wins) gnt_cyc_a = cyc;
        else gnt_cyc_b = cyc;
      end
      if (bus.done_a) begin
        if (exp_a.size() == 0) check("unexpected_done_a", bus.done_a, 0);
        else begin
          n_pop = exp_a.pop_front();
          e_pop = ref_sum(n_pop);
          check("res_a", bus.res_a, e_pop);
          check("latency_a", cyc - gnt_cyc_a, n_pop + 2);
          check("busy_at_done_a", bus.busy, 0);
          last_a = WIDTH'(e_pop);
          $display("[TB] A: N=%0d res=%0d expected=%0d latency=%0d", n_pop, bus.res_a, e_pop,
                   cyc - gnt_cyc_a);
        end
        idle_m = 1'b1;
      end else check("res_a_hold", bus.res_a, last_a);
      if (bus.done_b) begin
        if (exp_b.size() == 0) check("unexpected_done_b", bus.done_b, 0);
        else begin
          n_pop = exp_b.pop_front();
          e_pop = ref_sum(n_pop);
          check("res_b", bus.res_b, e_pop);
          check("latency_b", cyc - gnt_cyc_b, n_pop + 2);
          check("busy_at_done_b", bus.busy, 0);
          last_b = WIDTH'(e_pop);
          $display("[TB] B: N=%0d res=%0d expected=%0d latency=%0d", n_pop, bus.res_b, e_pop,
                   cyc - gnt_cyc_b);
        end
        idle_m = 1'b1;
      end else check("res_b_hold", bus.res_b, last_b);
    end
  end

  // Raise a request, hold it until its grant is seen, then drop it
  task automatic issue(input bit side, input int n);
    int k;
    bit got;
    if (!side) begin
      bus.lim_a = LIM_W'(n);
      bus.req_a = 1'b1;
      exp_a.push_back(n);
    end else begin
      bus.lim_b = LIM_W'(n);
      bus.req_b = 1'b1;
      exp_b.push_back(n);
    end
    k   = 0;
    got = 1'b0;
    while (!got && k < 300) begin
      @(posedge clk);
      k++;
      got = side ? bus.gnt_b : bus.gnt_a;
    end
    #1;
    if (!side) bus.req_a = 1'b0;
    else bus.req_b = 1'b0;
    check(side ? "gnt_b_seen" : "gnt_a_seen", got, 1);
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while ((exp_a.size() != 0 || exp_b.size() != 0 || bus.busy) && k < 600) begin
      @(posedge clk);
      #1;
      k++;
    end
    check("drained_and_idle", (exp_a.size() != 0) || (exp_b.size() != 0) || bus.busy, 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_gnt_a"}, bus.gnt_a, 0);
    check({tag, "_gnt_b"}, bus.gnt_b, 0);
    check({tag, "_done_a"}, bus.done_a, 0);
    check({tag, "_done_b"}, bus.done_b, 0);
    check({tag, "_res_a"}, bus.res_a, 0);
    check({tag, "_res_b"}, bus.res_b, 0);
    check({tag, "_busy"}, bus.busy, 0);
  endtask

  initial begin
    int mode, na, nb, gap;
    bus.req_a = 1'b0;
    bus.req_b = 1'b0;
    bus.lim_a = '0;
    bus.lim_b = '0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    reset = 1'b0;
    @(posedge clk);
    #1;

    issue(0, 10);
    wait_idle();
    issue(1, 20);
    wait_idle();

    // Tie, then A re-requests while B waits: B must beat A's second request
    fork
      begin
        issue(0, 3);
        issue(0, 3);
      end
      issue(1, 4);
    join
    wait_idle();
    fork
      issue(0, 5);
      issue(1, 6);
    join
    wait_idle();

    issue(0, 0);
    wait_idle();
    issue(0, 31);
    wait_idle();

    // lim_a disturbed mid-operation and B raised while busy
    issue(0, 10);
    repeat (4) @(posedge clk);
    #1;
    bus.lim_a = LIM_W'(2);
    issue(1, 9);
    wait_idle();

    // Reset during ACCUM aborts silently
    issue(0, 20);
    repeat (6) @(posedge clk);
    #1;
    reset = 1'b1;
    exp_a.delete();
    exp_b.delete();
    #1;
    check_all_zero("midreset");
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    issue(0, 10);
    wait_idle();

    for (int i = 0; i < 25; i++) begin
      mode = $urandom_range(2);
      na   = $urandom_range(31);
      nb   = $urandom_range(31);
      gap  = $urandom_range(3);
      case (mode)
        0: issue(0, na);
        1: issue(1, nb);
        default: fork
          issue(0, na);
          issue(1, nb);
        join
      endcase
      if (gap > 0) begin
        repeat (gap) @(posedge clk);
        #1;
      end
    end
    wait_idle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

endmodule

// File: doc/acc_sum_arbiter.md
Name: acc_sum_arbiter

Overview:
- Shares one counter/accumulator/adder datapath between two requesters, A and B.
- Each requester asks for the running sum 1+2+...+N, with N supplied at request time.
- The block round-robin arbitrates, sequences the datapath through clear/accumulate/write, and returns the result to the granted requester with a one-cycle done pulse.
- It is the programmable replacement for hard-wired sum sequencing in the accumulator datapath.

Parameters:
- WIDTH, 8, width of the counter, W accumulator and result registers; all sums are modulo 2^WIDTH.
- LIM_W, 5, width of the limit inputs; N ranges 0..2^LIM_W-1.

Ports:
- clk  input  1  clock; all registers update on the falling edge.
- reset  input  1  asynchronous, active-high reset.
- req_a  input  1  request from A, level; held until gnt_a is seen.
- lim_a  input  LIM_W  N for requester A; sampled only on A's grant edge.
- req_b  input  1  request from B, level.
- lim_b  input  LIM_W  N for requester B.
- gnt_a  output  1  one-cycle pulse; A won arbitration, lim_a captured.
- gnt_b  output  1  one-cycle pulse for B.
- done_a  output  1  one-cycle pulse; res_a holds the new result.
- done_b  output  1  one-cycle pulse for B.
- res_a  output  WIDTH  last result for A; held until A's next completion.
- res_b  output  WIDTH  last result for B.
- busy  output  1  high in every state except IDLE.

Behaviour:
- Reset values: all outputs 0; state IDLE; count, W and latched limit 0; round-robin pointer favours A.
- State machine (registered): IDLE -> LOAD -> ACCUM -> WRITE -> IDLE.
- IDLE:
  - If any req is high, select a winner, latch its lim into lim_r, record the owner, pulse its gnt, and go to LOAD.
  - With both requests high, the requester not granted most recently wins.
  - The pointer updates on every grant.
- LOAD:
  - count <= 0, W <= 0.
  - If lim_r == 0, go to WRITE; otherwise go to ACCUM.
- ACCUM:
  - Each edge: count <= count+1, W <= W + (count+1), truncated to WIDTH.
  - Leave for WRITE on the edge where count+1 == lim_r, so ACCUM lasts exactly N cycles.
- WRITE: the owner's res <= W; the owner's done pulses for the following cycle; go to IDLE.
- Latency:
  - Grant edge is e0; done is high for the cycle after edge e0+N+2.
  - The earliest next grant is edge e0+N+3.
- Requests arriving while busy are ignored until IDLE. A req still high after done is treated as a new request.
- The non-owner's res, done and gnt are never disturbed.
- Overflow wraps silently (e.g. N=31 gives 496 mod 256 = 240 for WIDTH=8); there is no saturation or flag.
- Changes on lim_x after the grant edge have no effect on the operation in flight.
- Reset asserted mid-operation:
  - Immediately returns to IDLE and clears res_a/res_b.
  - No done or gnt is emitted for the aborted operation.
  - The pointer returns to favour A.
- gnt and done never assert in the same cycle for the same requester; at most one gnt per cycle.

Decomposition:
- Package acc_sched_pkg holds:
  - the state enum (IDLE, LOAD, ACCUM, WRITE);
  - the owner encoding (OWN_A=0, OWN_B=1);
  - default WIDTH/LIM_W constants.
- Sub-module acc_datapath (WIDTH):
  - Inputs: clr, cnt_en, load_w.
  - Outputs: count, W, sum = count+1+W.
  - Holds the counter, the W register and the adder; the FSM, arbiter and result registers stay in the top.

Test Plan:
- Reset then req_a=1, lim_a=10, held until gnt_a -> gnt_a at e0, done_a after edge e0+12, res_a=55, res_b stays 0, busy low afterward.
- req_b=1, lim_b=20 -> res_b=210 (0xD2), done_b exactly 22 edges after gnt_b.
- req_a and req_b raised together, lim_a=3, lim_b=4, both held:
  - A is granted first (res_a=6), then B on the first IDLE edge (res_b=10).
  - Repeat with both held again -> B is granted before A.
- lim_a=0 -> done_a 2 edges after gnt_a with res_a=0; lim_a=31, WIDTH=8 -> res_a=240 (wrap).
- During A's ACCUM with lim_a=10, change lim_a to 2 and raise req_b -> res_a still 55; gnt_b only after done_a; B's result is correct.
- Assert reset during ACCUM -> outputs 0 immediately, no done pulse; a fresh request afterward completes normally.
